// File: rtl/rdft_pkg.sv
// rtl/rdft_pkg.sv - shared types and widths for the RDFT datapath stages
package rdft_pkg;

    // Input sample magnitude width; stage samples carry one extra bit of headroom
    localparam int BITS     = 31;
    localparam int SAMPLE_W = BITS + 1;

    // Complex sample as carried between RDFT stages
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    // Butterfly stage phase within a 2D-sample frame
    typedef enum logic {
        FILL = 1'b0,
        BFLY = 1'b1
    } phase_t;

endpackage

// File: rtl/r2sdf_delay.sv
// rtl/r2sdf_delay.sv - D-entry circular delay line, read-before-write at a single pointer
module r2sdf_delay #(
    parameter int DW     = 64,
    parameter int LOG2_D = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int D = 1 << LOG2_D;

    logic [DW-1:0]     mem [D];
    logic [LOG2_D-1:0] ptr;

    // Head of the line is the entry written D accepted samples ago
    assign rdata = mem[ptr];

    // Pointer steps once per accepted sample; D is a power of two so it wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Storage is not reset; it is always overwritten before it is consumed as valid data
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= wdata;
        end
    end

endmodule

// File: rtl/r2sdf_bfly_stage.sv
// rtl/r2sdf_bfly_stage.sv - radix-2 single-path delay-feedback butterfly stage with 1/2 scaling
module r2sdf_bfly_stage
    import rdft_pkg::*;
#(
    parameter int W      = SAMPLE_W,
    parameter int LOG2_D = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    output logic                out_sof,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im
);

    localparam int D = 1 << LOG2_D;
    localparam logic [LOG2_D:0] CNT_LAST_FILL  = (LOG2_D+1)'(D - 1);
    localparam logic [LOG2_D:0] CNT_FIRST_BFLY = (LOG2_D+1)'(D);

    logic [LOG2_D:0]     cnt;
    logic [LOG2_D:0]     cnt_eff;
    logic                primed;
    logic                primed_eff;
    phase_t              phase;
    logic [2*W-1:0]      dly_wdata;
    logic [2*W-1:0]      dly_rdata;
    logic signed [W-1:0] a_re, a_im;
    logic signed [W:0]   a_re_x, a_im_x, b_re_x, b_im_x;
    logic signed [W-1:0] s_re, s_im, d_re, d_im;

    // A start-of-frame restarts the count and forgets that a previous frame was completed
    assign cnt_eff    = in_sof ? '0 : cnt;
    assign primed_eff = primed & ~in_sof;
    assign phase      = cnt_eff[LOG2_D] ? BFLY : FILL;

    assign a_re = dly_rdata[2*W-1:W];
    assign a_im = dly_rdata[W-1:0];

    // One guard bit makes the sum/difference exact; floor-halving brings it back into W bits
    assign a_re_x = {a_re[W-1], a_re};
    assign a_im_x = {a_im[W-1], a_im};
    assign b_re_x = {in_re[W-1], in_re};
    assign b_im_x = {in_im[W-1], in_im};
    assign s_re   = W'((a_re_x + b_re_x) >>> 1);
    assign s_im   = W'((a_im_x + b_im_x) >>> 1);
    assign d_re   = W'((a_re_x - b_re_x) >>> 1);
    assign d_im   = W'((a_im_x - b_im_x) >>> 1);

    // FILL stores the new sample; BFLY feeds the scaled difference back into the line
    assign dly_wdata = (phase == BFLY) ? {d_re, d_im} : {in_re, in_im};

    r2sdf_delay #(
        .DW     (2 * W),
        .LOG2_D (LOG2_D)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .en    (in_valid),
        .wdata (dly_wdata),
        .rdata (dly_rdata)
    );

    // Frame counter, primed flag and registered outputs advance only on accepted samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (in_valid) begin
            cnt <= cnt_eff + 1'b1;
            if (cnt_eff == CNT_LAST_FILL) begin
                primed <= 1'b1;
            end else if (in_sof) begin
                primed <= 1'b0;
            end
            out_sof <= (cnt_eff == CNT_FIRST_BFLY);
            if (phase == BFLY) begin
                out_valid <= 1'b1;
                out_re    <= s_re;
                out_im    <= s_im;
            end else begin
                out_valid <= primed_eff;
                out_re    <= a_re;
                out_im    <= a_im;
            end
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end
    end

endmodule
